// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with a direct-select mode and an
// auto-scanning mode that walks the active line, holding each for DWELL clocks.
module scan_decoder #(
    parameter int SEL_W      = 2,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic [2**SEL_W-1:0] y,
    output logic [SEL_W-1:0]   idx,
    output logic               valid,
    output logic               wrap
);

    localparam int OUT_N = 2**SEL_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(OUT_N - 1);
    localparam logic [OUT_N-1:0] OFF = {OUT_N{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;
    logic [OUT_N-1:0]   y_q, y_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            y_q     <= OFF;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = '0;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        if (!en) begin
            state_d = IDLE;
        end else if (!mode) begin
            state_d = DIRECT;
            idx_d   = sel;
            valid_d = 1'b1;
        end else begin
            state_d = SCAN;
            valid_d = 1'b1;
            // Any entry into SCAN restarts at line 0 with a fresh dwell.
            if (state_q != SCAN) begin
                idx_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                idx_d  = idx_q + SEL_W'(1);
                wrap_d = (idx_q == LAST);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        y_d = OFF;
        if (valid_d) begin
            y_d = OFF ^ (OUT_N'(1) << idx_d);
        end
    end

    assign y     = y_q;
    assign idx   = idx_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: a 2-bit/DWELL=4 instance and a
// 3-bit/DWELL=1/active-low instance share control stimulus.
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] sel0 = '0;
    logic [2:0] sel1 = '0;
    logic [3:0] y0;
    logic [1:0] idx0;
    logic       v0, w0;
    logic [7:0] y1;
    logic [2:0] idx1;
    logic       v1, w1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(2), .DWELL(4), .ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel0),
        .y(y0), .idx(idx0), .valid(v0), .wrap(w0)
    );

    scan_decoder #(.SEL_W(3), .DWELL(1), .ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel1),
        .y(y1), .idx(idx1), .valid(v1), .wrap(w1)
    );

    // st: 0 idle, 1 direct, 2 scan; ticks counts clocks since scan entry
    typedef struct {
        int st;
        int ticks;
        int idx;
    } mst_t;

    typedef struct {
        logic [7:0] y;
        int         idx;
        bit         valid;
        bit         wrap;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    mst_t m0 = '{0, 0, 0};
    mst_t m1 = '{0, 0, 0};
    mst_t n0, n1;
    exp_t e0, e1, a0, a1;

    task automatic model_step(input mst_t s, input bit r, input bit e,
                              input bit md, input int sl, input int sw,
                              input int dw, input bit al,
                              output mst_t ns, output exp_t ex);
        int n;
        n = 1 << sw;
        ns = s;
        ex.valid = 1'b0;
        ex.wrap = 1'b0;
        if (r) begin
            ns.st = 0;
            ns.ticks = 0;
            ns.idx = 0;
        end else if (!e) begin
            ns.st = 0;
        end else if (!md) begin
            ns.st = 1;
            ns.idx = sl % n;
            ex.valid = 1'b1;
        end else if (s.st != 2) begin
            ns.st = 2;
            ns.ticks = 0;
            ns.idx = 0;
            ex.valid = 1'b1;
        end else begin
            ns.ticks = s.ticks + 1;
            ns.idx = (ns.ticks / dw) % n;
            ex.wrap = (ns.ticks % (dw * n)) == 0;
            ex.valid = 1'b1;
        end
        ex.idx = ns.idx;
        ex.y = ex.valid ? 8'(1 << ns.idx) : 8'h00;
        if (al) ex.y = ~ex.y & 8'((1 << n) - 1);
    endtask

    task automatic check(input string nm, input logic [7:0] y,
                         input logic [2:0] idx, input logic v,
                         input logic w, input exp_t e);
        checks++;
        if (y !== e.y || idx !== 3'(e.idx) || v !== e.valid || w !== e.wrap) begin
            errors++;
            $display("FAIL %s t=%0t got y=%h idx=%0d valid=%b wrap=%b want y=%h idx=%0d valid=%b wrap=%b",
                     nm, $time, y, idx, v, w, e.y, e.idx, e.valid, e.wrap);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step(m0, rst, en, mode, int'(sel0), 2, 4, 1'b0, n0, e0);
        m0 = n0;
        q0.push_back(e0);
        model_step(m1, rst, en, mode, int'(sel1), 3, 1, 1'b1, n1, e1);
        m1 = n1;
        q1.push_back(e1);
    end

    initial forever begin
        @(negedge clk);
        if (q0.size() > 0) begin
            a0 = q0.pop_front();
            check("dut0", {4'h0, y0}, {1'b0, idx0}, v0, w0, a0);
        end
        if (q1.size() > 0) begin
            a1 = q1.pop_front();
            check("dut1", y1, idx1, v1, w1, a1);
        end
    end

    task automatic cyc(input bit r, input bit e, input bit m, input int s);
        rst = r;
        en = e;
        mode = m;
        sel0 = 2'(s);
        sel1 = 3'(s);
        @(posedge clk);
        #1;
    endtask

    bit rr, re, rm;

    initial begin
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, i);
        repeat (20) cyc(0, 1, 1, 0);
        cyc(0, 0, 0, 0);
        repeat (9) cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 1);
        cyc(0, 1, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        repeat (16) cyc(0, 1, 1, 0);
        cyc(1, 1, 1, 0);
        cyc(0, 0, 0, 0);
        repeat (20) cyc(0, 1, 1, 0);
        rm = 1'b1;
        repeat (800) begin
            rr = ($urandom_range(0, 59) == 0);
            re = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) rm = ~rm;
            cyc(rr, re, rm, int'($urandom_range(0, 7)));
        end
        cyc(0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
